pc_fetch_unit: RTL and testbench

- Consumer of the 2-bit next-PC select code produced by the branch/jump control block.
- Owns the program counter and computes the redirect target.
- Fetches instructions through a req/ready instruction-memory handshake and hands them to decode through a valid/ready output buffered by a one-entry skid register.
- Sits between instruction memory and the IF/ID stage.

---
 rtl/pc_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program-counter owner and instruction fetch front end: redirect target
// generation, imem req/ready handshake, and a skid-buffered valid/ready output to decode.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  sel_in,
   input  logic [31:0] br_pc4,
   input  logic [31:0] br_imm,
   input  logic [25:0] j_index,
   input  logic [31:0] jr_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] instr_out,
   output logic [31:0] pc_out
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_SQUASH
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] hold_q, hold_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic        skid_valid_q, skid_valid_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [31:0] skid_pc_q, skid_pc_d;

   logic [31:0] target;
   logic        redirect;
   logic        req;
   logic        fire;

   always_comb begin
      target = pc_q;
      unique case (sel_in)
         2'b01:   target = br_pc4 + {br_imm[29:0], 2'b00};
         2'b10:   target = {br_pc4[31:28], j_index, 2'b00};
         2'b11:   target = {jr_addr[31:2], 2'b00};
         default: target = pc_q;
      endcase
   end

   assign redirect  = (sel_in != 2'b00) && (state_q != S_IDLE);
   // Requests stop while the skid is full, so a response always has a place to land.
   assign req       = ((state_q == S_FETCH) && !skid_valid_q) || (state_q == S_SQUASH);
   assign fire      = req && imem_ready;

   assign imem_req  = req;
   assign imem_addr = (state_q == S_SQUASH) ? hold_q : pc_q;
   assign out_valid = out_valid_q;
   assign instr_out = instr_q;
   assign pc_out    = pc_out_q;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      hold_d       = hold_q;
      out_valid_d  = out_valid_q;
      instr_d      = instr_q;
      pc_out_d     = pc_out_q;
      skid_valid_d = skid_valid_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;

      if (redirect) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
         pc_d         = target;
      end else if (out_valid_q && out_ready) begin
         if (skid_valid_q) begin
            instr_d      = skid_instr_q;
            pc_out_d     = skid_pc_q;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d = 1'b0;
         end
      end

      unique case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            if (redirect) begin
               // An accepted-but-unanswered request must be completed at its old address.
               if (req && !imem_ready) begin
                  state_d = S_SQUASH;
                  hold_d  = pc_q;
               end
            end else if (fire) begin
               pc_d = pc_q + 32'd4;
               if (!out_valid_q || out_ready) begin
                  out_valid_d = 1'b1;
                  instr_d     = imem_rdata;
                  pc_out_d    = pc_q;
               end else begin
                  skid_valid_d = 1'b1;
                  skid_instr_d = imem_rdata;
                  skid_pc_d    = pc_q;
               end
            end
         end
         S_SQUASH: begin
            if (imem_ready) state_d = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         hold_q       <= '0;
         out_valid_q  <= 1'b0;
         instr_q      <= '0;
         pc_out_q     <= '0;
         skid_valid_q <= 1'b0;
         skid_instr_q <= '0;
         skid_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         hold_q       <= hold_d;
         out_valid_q  <= out_valid_d;
         instr_q      <= instr_d;
         pc_out_q     <= pc_out_d;
         skid_valid_q <= skid_valid_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table for the fetch/redirect/squash
// scenarios, then randomized traffic against a queue-based reference model.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  sel_in;
   logic [31:0] br_pc4, br_imm, jr_addr;
   logic [25:0] j_index;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] instr_out, pc_out;

   int checks = 0;
   int errors = 0;

   pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk       (clk),
      .rst       (rst),
      .sel_in    (sel_in),
      .br_pc4    (br_pc4),
      .br_imm    (br_imm),
      .j_index   (j_index),
      .jr_addr   (jr_addr),
      .imem_req  (imem_req),
      .imem_addr (imem_addr),
      .imem_ready(imem_ready),
      .imem_rdata(imem_rdata),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .instr_out (instr_out),
      .pc_out    (pc_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [1:0]  sel;
      logic [31:0] pc4;
      logic [31:0] imm;
      logic [25:0] jidx;
      logic [31:0] jr;
      logic        rdy;
      logic        ordy;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_ov;
      logic [31:0] e_pc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic [1:0] s, logic [31:0] p4, logic [31:0] im,
                               logic [25:0] ji, logic [31:0] j, logic rd, logic od,
                               logic eq, logic [31:0] ea, logic eo, logic [31:0] ep);
      vec_t v;
      v.rst = r; v.sel = s; v.pc4 = p4; v.imm = im; v.jidx = ji; v.jr = j;
      v.rdy = rd; v.ordy = od; v.e_req = eq; v.e_addr = ea; v.e_ov = eo; v.e_pc = ep;
      return v;
   endfunction

   function automatic logic [31:0] mem_word(logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: the output register plus skid behave as a 2-deep queue.
   typedef enum int {M_IDLE, M_FETCH, M_SQUASH} mmode_e;
   mmode_e      m_mode;
   logic [31:0] m_pc, m_hold;
   logic [63:0] m_q[$];

   function automatic logic [31:0] ref_target(logic [1:0] s, logic [31:0] p4, logic [31:0] im,
                                              logic [25:0] ji, logic [31:0] j);
      case (s)
         2'b01:   return p4 + im * 32'd4;
         2'b10:   return (p4 & 32'hF000_0000) | ({6'b0, ji} << 2);
         default: return j & 32'hFFFF_FFFC;
      endcase
   endfunction

   function automatic logic m_req();
      return (m_mode == M_SQUASH) || (m_mode == M_FETCH && m_q.size() < 2);
   endfunction

   task automatic model_step();
      logic r;
      r = m_req();
      if (rst) begin
         m_mode = M_IDLE; m_pc = 32'h0; m_q.delete();
      end else if (m_mode == M_IDLE) begin
         m_mode = M_FETCH;
      end else if (sel_in != 2'b00) begin
         m_q.delete();
         if (m_mode == M_FETCH && r && !imem_ready) begin
            m_mode = M_SQUASH; m_hold = m_pc;
         end else if (m_mode == M_SQUASH && imem_ready) begin
            m_mode = M_FETCH;
         end
         m_pc = ref_target(sel_in, br_pc4, br_imm, j_index, jr_addr);
      end else begin
         if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
         if (m_mode == M_FETCH && r && imem_ready) begin
            m_q.push_back({imem_rdata, m_pc});
            m_pc = m_pc + 32'd4;
         end else if (m_mode == M_SQUASH && imem_ready) begin
            m_mode = M_FETCH;
         end
      end
   endtask

   initial begin
      rst = 1'b1; sel_in = '0; br_pc4 = '0; br_imm = '0; j_index = '0; jr_addr = '0;
      imem_ready = 1'b0; imem_rdata = '0; out_ready = 1'b0;

      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 3, 0, 0, 0, 32'h999, 1, 1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h4, 1, 32'h0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h8, 1, 32'h4));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h4));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h4));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'hC, 1, 32'h8));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h10, 1, 32'hC));
      vecs.push_back(mk(0, 1, 32'h10, 32'hFFFF_FFFE, 0, 0, 1, 1, 1, 32'h8, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'hC, 1, 32'h8));
      vecs.push_back(mk(0, 2, 32'h8000_0010, 0, 26'h40, 0, 1, 1, 1, 32'h8000_0100, 0, 0));
      vecs.push_back(mk(0, 3, 0, 0, 0, 32'h1233, 1, 1, 1, 32'h1230, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h1234, 1, 32'h1230));
      vecs.push_back(mk(0, 3, 0, 0, 0, 32'h20, 1, 1, 1, 32'h20, 0, 0));
      vecs.push_back(mk(0, 3, 0, 0, 0, 32'h200, 0, 1, 1, 32'h20, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h20, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h200, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h204, 1, 32'h200));
      vecs.push_back(mk(0, 3, 0, 0, 0, 32'h300, 0, 1, 1, 32'h204, 0, 0));
      vecs.push_back(mk(0, 3, 0, 0, 0, 32'h400, 0, 1, 1, 32'h204, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h400, 0, 0));
      vecs.push_back(mk(0, 3, 0, 0, 0, 32'h500, 0, 1, 1, 32'h400, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 3, 0, 0, 0, 32'h777, 1, 1, 1, 32'h0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h4, 1, 32'h0));

      @(negedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst; sel_in = vecs[i].sel; br_pc4 = vecs[i].pc4; br_imm = vecs[i].imm;
         j_index = vecs[i].jidx; jr_addr = vecs[i].jr; imem_ready = vecs[i].rdy;
         out_ready = vecs[i].ordy; imem_rdata = mem_word(imem_addr);
         @(negedge clk);
         chk($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].e_req});
         if (vecs[i].e_req) chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
         chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_ov});
         if (vecs[i].e_ov) begin
            chk($sformatf("v%0d_pc_out", i), pc_out, vecs[i].e_pc);
            chk($sformatf("v%0d_instr", i), instr_out, mem_word(vecs[i].e_pc));
         end
         if (vecs[i].rst) begin
            chk($sformatf("v%0d_rst_pc_out", i), pc_out, 32'h0);
            chk($sformatf("v%0d_rst_instr", i), instr_out, 32'h0);
         end
      end

      rst = 1'b1; sel_in = '0; imem_ready = 1'b0; out_ready = 1'b0;
      model_step();
      @(negedge clk);
      for (int c = 0; c < 4000; c++) begin
         chk($sformatf("r%0d_req", c), {31'b0, imem_req}, {31'b0, m_req()});
         if (m_req()) chk($sformatf("r%0d_addr", c), imem_addr,
                          (m_mode == M_SQUASH) ? m_hold : m_pc);
         chk($sformatf("r%0d_valid", c), {31'b0, out_valid}, {31'b0, m_q.size() > 0});
         if (m_q.size() > 0) begin
            chk($sformatf("r%0d_pc_out", c), pc_out, m_q[0][31:0]);
            chk($sformatf("r%0d_instr", c), instr_out, m_q[0][63:32]);
         end
         rst        = ($urandom_range(0, 149) == 0);
         sel_in     = ($urandom_range(0, 9) < 8) ? 2'b00 : 2'($urandom_range(1, 3));
         br_pc4     = $urandom;
         br_imm     = $urandom;
         j_index    = 26'($urandom);
         jr_addr    = $urandom;
         imem_ready = ($urandom_range(0, 9) < 7);
         out_ready  = ($urandom_range(0, 9) < 7);
         imem_rdata = $urandom;
         model_step();
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
